// File: rtl/matmul_apb_slave.sv
// APB register slave for a matrix-multiply engine: CTRL/START, sticky DONE status and DATA registers.
// Optional macro MATMUL_APB_SLVERR_EN enables pslverr_o reporting; without it pslverr_o is tied low.
module matmul_apb_slave #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic                              pwrite_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0]   pstrb_i,
    input  logic [BUS_WIDTH-1:0]              pwdata_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    output logic                              pready_o,
    output logic                              pslverr_o,
    output logic [BUS_WIDTH-1:0]              prdata_o,
    input  logic                              busy_i,
    input  logic                              done_i,
    output logic                              busy_o,
    output logic                              start_o,
    output logic [NUM_REGS*BUS_WIDTH-1:0]     regs_o
);
    localparam int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH;
    localparam int OFFS_W     = $clog2(BUS_WIDTH / 8);
    localparam int IDX_W      = $clog2(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [BUS_WIDTH-1:0]    wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic                    err_q;

    logic [BUS_WIDTH-1:0]    data_q [NUM_REGS];
    logic [2:0]              mode_q;
    logic                    done_q;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   cur_idx_full;
    logic [IDX_W-1:0]        cur_idx;
    logic                    cur_write;
    logic [BUS_WIDTH-1:0]    cur_wdata;
    logic                    in_range;
    logic [BUS_WIDTH-1:0]    rd_val;
    logic                    req_err;
    logic                    commit;

    // Decode from the live bus during setup so a zero-wait access can answer on the first access cycle.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        cur_addr     = (state_q == IDLE) ? paddr_i  : addr_q;
        cur_write    = (state_q == IDLE) ? pwrite_i : write_q;
        cur_wdata    = (state_q == IDLE) ? pwdata_i : wdata_q;
        cur_idx_full = cur_addr >> OFFS_W;
        cur_idx      = cur_idx_full[IDX_W-1:0];
        in_range     = cur_idx_full < ADDR_WIDTH'(NUM_REGS);
        rd_val       = '0;
        req_err      = !in_range;
        if (in_range) begin
            if (cur_write) begin
                // STATUS is exempt from the busy lock so DONE can always be acknowledged.
                if (cur_idx == IDX_W'(1)) req_err = !cur_wdata[1];
                else                      req_err = busy_i;
            end else begin
                case (cur_idx)
                    IDX_W'(0): rd_val[3:1] = mode_q;
                    IDX_W'(1): rd_val[1:0] = {done_q, busy_i};
                    default:   rd_val      = data_q[cur_idx];
                endcase
            end
        end
    end

    // The error decision is frozen when pready rises; the commit honours that same decision.
    assign commit = (state_q == ACCESS) && psel_i && penable_i && pready_o && write_q && !err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            err_q    <= 1'b0;
            pready_o <= 1'b0;
            prdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_q <= ACCESS;
                        cnt_q   <= 3'(WAIT_STATES);
                        addr_q  <= paddr_i;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        strb_q  <= pstrb_i;
                        if (WAIT_STATES == 0) begin
                            pready_o <= 1'b1;
                            err_q    <= req_err;
                            prdata_o <= rd_val;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel_i || (penable_i && pready_o)) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        pready_o <= 1'b0;
                        err_q    <= 1'b0;
                        prdata_o <= '0;
                    end else if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            pready_o <= 1'b1;
                            err_q    <= req_err;
                            prdata_o <= rd_val;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the register file is reset explicitly because software expects all-zero contents after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) data_q[r] <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            start_o <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (commit) begin
                if (cur_idx == IDX_W'(0)) begin
                    for (int j = 1; j <= 3; j++)
                        if (strb_q[j / DATA_WIDTH]) mode_q[j-1] <= wdata_q[j];
                    start_o <= strb_q[0] && wdata_q[0];
                end else if (cur_idx != IDX_W'(1)) begin
                    for (int k = 0; k < STRB_WIDTH; k++)
                        if (strb_q[k])
                            data_q[cur_idx][k*DATA_WIDTH +: DATA_WIDTH] <= wdata_q[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            // A new done event wins over a coincident acknowledge.
            if (done_i)
                done_q <= 1'b1;
            else if (commit && cur_idx == IDX_W'(1) && wdata_q[1])
                done_q <= 1'b0;
        end
    end

    always_comb begin
        regs_o = '0;
        regs_o[3:1] = mode_q;
        regs_o[BUS_WIDTH +: 2] = {done_q, busy_i};
        for (int k = 2; k < NUM_REGS; k++) regs_o[k*BUS_WIDTH +: BUS_WIDTH] = data_q[k];
    end

    assign busy_o = busy_i;

`ifdef MATMUL_APB_SLVERR_EN
    assign pslverr_o = err_q;
`else
    assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Self-checking bench for matmul_apb_slave with WAIT_STATES=2; directed scenarios plus randomized traffic vs a register model.
`timescale 1ns/1ps
module tb_matmul_apb_slave;
    localparam int BW = 32, AW = 16, DW = 8, NR = 8, WS = 2, SW = BW / DW;
`ifdef MATMUL_APB_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic psel = 0, penable = 0, pwrite = 0, busy = 0, done = 0;
    logic [SW-1:0] pstrb = '0;
    logic [BW-1:0] pwdata = '0;
    logic [AW-1:0] paddr = '0;
    logic pready, pslverr, busy_out, start;
    logic [BW-1:0] prdata;
    logic [NR*BW-1:0] regs;

    int checks = 0, failures = 0;

    // Behavioural register model
    logic [BW-1:0] m_data [NR];
    logic [2:0]    m_mode;
    logic          m_done;

    matmul_apb_slave #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .pstrb_i(pstrb), .pwdata_i(pwdata), .paddr_i(paddr), .pready_o(pready), .pslverr_o(pslverr),
        .prdata_o(prdata), .busy_i(busy), .done_i(done), .busy_o(busy_out), .start_o(start), .regs_o(regs)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) m_data[r] = '0;
        m_mode = '0;
        m_done = 1'b0;
    endfunction

    function automatic logic [BW-1:0] model_read(int idx, logic b);
        if (idx >= NR) return '0;
        if (idx == 0) return {28'd0, m_mode, 1'b0};
        if (idx == 1) return {30'd0, m_done, b};
        return m_data[idx];
    endfunction

    function automatic logic model_err(logic wr, int idx, logic [BW-1:0] wd, logic b);
        if (idx >= NR) return 1'b1;
        if (!wr) return 1'b0;
        if (idx == 1) return !wd[1];
        return b;
    endfunction

    function automatic void model_write(int idx, logic [BW-1:0] wd, logic [SW-1:0] st);
        if (idx == 0) begin
            if (st[0]) m_mode = wd[3:1];
        end else if (idx == 1) begin
            if (wd[1]) m_done = 1'b0;
        end else begin
            for (int k = 0; k < SW; k++)
                if (st[k]) m_data[idx][k*DW +: DW] = wd[k*DW +: DW];
        end
    endfunction

    // One APB transfer; returns at the falling edge after the completion edge.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                            input logic [SW-1:0] st, input logic pulse_done,
                            output logic [BW-1:0] rd, output logic err, output int waits);
        bit ok = 1'b0;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable = 1; waits = 0; rd = '0; err = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (pready === 1'b1) begin
                ok = 1'b1; rd = prdata; err = pslverr;
                if (pulse_done) done = 1'b1;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL apb_timeout: addr=%h pready never rose within 16 cycles", addr);
        end
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0; done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (pready !== 1'b0)  begin failures++; $display("FAIL reset_pready: got %b want 0", pready); end
        if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        if (prdata !== '0)    begin failures++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        if (start !== 1'b0)   begin failures++; $display("FAIL reset_start: got %b want 0", start); end
        if (regs !== '0)      begin failures++; $display("FAIL reset_regs: got %h want 0", regs); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_wait_states();
        logic [BW-1:0] rd; logic er; int w;
        apb_xfer(1, 16'h0008, 32'hA5A5A5A5, 4'b1111, 0, rd, er, w);
        model_write(2, 32'hA5A5A5A5, 4'b1111);
        checks += 3;
        if (w !== WS)       begin failures++; $display("FAIL ws_write_waits: got %0d want %0d", w, WS); end
        if (er !== 1'b0)    begin failures++; $display("FAIL ws_write_err: got %b want 0", er); end
        if (pready !== 1'b0) begin failures++; $display("FAIL ws_pready_one_cycle: got %b want 0", pready); end
        apb_xfer(0, 16'h0008, 32'h0, 4'b0000, 0, rd, er, w);
        checks += 3;
        if (rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL ws_readback: got %h want a5a5a5a5", rd); end
        if (w !== WS)            begin failures++; $display("FAIL ws_read_waits: got %0d want %0d", w, WS); end
        if (er !== 1'b0)         begin failures++; $display("FAIL ws_read_err: got %b want 0", er); end
    endtask

    task automatic test_strobes();
        logic [BW-1:0] rd; logic er; int w;
        apb_xfer(1, 16'h000C, 32'h11223344, 4'b0101, 0, rd, er, w);
        model_write(3, 32'h11223344, 4'b0101);
        apb_xfer(0, 16'h000C, 32'h0, 4'b1111, 0, rd, er, w);
        checks += 2;
        if (rd !== 32'h00220044) begin failures++; $display("FAIL strobe_lanes: got %h want 00220044", rd); end
        if (regs[3*BW +: BW] !== m_data[3]) begin failures++; $display("FAIL strobe_regs_o: got %h want %h", regs[3*BW +: BW], m_data[3]); end
    endtask

    task automatic test_ctrl_start();
        logic [BW-1:0] rd; logic er; int w;
        busy = 0;
        apb_xfer(1, 16'h0000, 32'h1, 4'b1111, 0, rd, er, w);
        checks += 1;
        if (start !== 1'b1) begin failures++; $display("FAIL start_pulse: got %b want 1", start); end
        @(negedge clk);
        checks += 1;
        if (start !== 1'b0) begin failures++; $display("FAIL start_one_cycle: got %b want 0", start); end
        apb_xfer(0, 16'h0000, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'h0) begin failures++; $display("FAIL ctrl_reads_zero: got %h want 0", rd); end
        apb_xfer(1, 16'h0000, 32'hF, 4'b0001, 0, rd, er, w);
        m_mode = 3'b111;
        checks += 1;
        if (start !== 1'b1) begin failures++; $display("FAIL start_with_mode: got %b want 1", start); end
        apb_xfer(0, 16'h0000, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'hE) begin failures++; $display("FAIL ctrl_mode: got %h want e", rd); end

        busy = 1;
        @(negedge clk);
        checks += 1;
        if (busy_out !== 1'b1) begin failures++; $display("FAIL busy_o_high: got %b want 1", busy_out); end
        apb_xfer(1, 16'h0000, 32'h1, 4'b1111, 0, rd, er, w);
        checks += 2;
        if (start !== 1'b0)     begin failures++; $display("FAIL start_blocked: got %b want 0", start); end
        if (er !== SLVERR_EN)   begin failures++; $display("FAIL busy_ctrl_err: got %b want %b", er, SLVERR_EN); end
        apb_xfer(1, 16'h0008, 32'h5A5A5A5A, 4'b1111, 0, rd, er, w);
        apb_xfer(0, 16'h0008, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== m_data[2]) begin failures++; $display("FAIL busy_data_blocked: got %h want %h", rd, m_data[2]); end
        apb_xfer(0, 16'h0000, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'hE) begin failures++; $display("FAIL busy_ctrl_kept: got %h want e", rd); end
        busy = 0;
        @(negedge clk);
        checks += 1;
        if (busy_out !== 1'b0) begin failures++; $display("FAIL busy_o_low: got %b want 0", busy_out); end
    endtask

    task automatic test_out_of_range();
        logic [BW-1:0] rd; logic er; int w;
        apb_xfer(0, 16'h0040, 32'h0, 4'b0, 0, rd, er, w);
        checks += 2;
        if (rd !== 32'h0)     begin failures++; $display("FAIL oor_read_data: got %h want 0", rd); end
        if (er !== SLVERR_EN) begin failures++; $display("FAIL oor_read_err: got %b want %b", er, SLVERR_EN); end
        apb_xfer(1, 16'h0044, 32'hFFFFFFFF, 4'b1111, 0, rd, er, w);
        checks += 1;
        if (er !== SLVERR_EN) begin failures++; $display("FAIL oor_write_err: got %b want %b", er, SLVERR_EN); end
        apb_xfer(0, 16'h000B, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== m_data[2]) begin failures++; $display("FAIL byte_offset_ignored: got %h want %h", rd, m_data[2]); end
    endtask

    task automatic test_done();
        logic [BW-1:0] rd; logic er; int w;
        @(negedge clk); done = 1;
        @(negedge clk); done = 0;
        apb_xfer(0, 16'h0004, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'h2) begin failures++; $display("FAIL done_set: got %h want 2", rd); end
        apb_xfer(1, 16'h0004, 32'h1, 4'b1111, 0, rd, er, w);
        checks += 1;
        if (er !== SLVERR_EN) begin failures++; $display("FAIL status_bad_write_err: got %b want %b", er, SLVERR_EN); end
        apb_xfer(1, 16'h0004, 32'h2, 4'b1111, 1, rd, er, w);
        apb_xfer(0, 16'h0004, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'h2) begin failures++; $display("FAIL done_wins_clear: got %h want 2", rd); end
        apb_xfer(1, 16'h0004, 32'h2, 4'b1111, 0, rd, er, w);
        checks += 1;
        if (er !== 1'b0) begin failures++; $display("FAIL status_clear_err: got %b want 0", er); end
        apb_xfer(0, 16'h0004, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'h0) begin failures++; $display("FAIL done_cleared: got %h want 0", rd); end
        busy = 1;
        apb_xfer(0, 16'h0004, 32'h0, 4'b0, 0, rd, er, w);
        busy = 0;
        checks += 1;
        if (rd !== 32'h1) begin failures++; $display("FAIL status_busy_bit: got %h want 1", rd); end
        m_done = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [BW-1:0] rd; logic er; int w;
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = 16'h0008; pwdata = 32'hDEADBEEF; pstrb = 4'b1111;
        @(negedge clk); penable = 1;
        repeat (WS) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (pready !== 1'b0)  begin failures++; $display("FAIL abort_pready: got %b want 0", pready); end
        if (pslverr !== 1'b0) begin failures++; $display("FAIL abort_pslverr: got %b want 0", pslverr); end
        if (start !== 1'b0)   begin failures++; $display("FAIL abort_start: got %b want 0", start); end
        if (regs !== '0)      begin failures++; $display("FAIL abort_regs: got %h want 0", regs); end
        psel = 0; penable = 0; pwrite = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apb_xfer(0, 16'h0008, 32'h0, 4'b0, 0, rd, er, w);
        checks += 1;
        if (rd !== 32'h0) begin failures++; $display("FAIL abort_no_commit: got %h want 0", rd); end
        apb_xfer(1, 16'h0008, 32'h12345678, 4'b1111, 0, rd, er, w);
        apb_xfer(0, 16'h0008, 32'h0, 4'b0, 0, rd, er, w);
        m_data[2] = 32'h12345678;
        checks += 1;
        if (rd !== 32'h12345678) begin failures++; $display("FAIL post_reset_xfer: got %h want 12345678", rd); end
    endtask

    task automatic test_random();
        logic [BW-1:0] rd, wd, exp_rd; logic er, wr, b, exp_err, exp_start; int w, idx;
        logic [SW-1:0] st;
        for (int i = 0; i < 60; i++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, NR + 1));
            wd  = $urandom;
            st  = SW'($urandom_range(0, 15));
            b   = ($urandom_range(0, 3) == 0);
            if (wr && idx == 1 && b) b = 1'b0;
            busy = b;
            exp_err   = model_err(wr, idx, wd, b);
            exp_rd    = (wr || exp_err) ? '0 : model_read(idx, b);
            exp_start = wr && !exp_err && idx == 0 && st[0] && wd[0];
            apb_xfer(wr, AW'(idx * 4 + int'($urandom_range(0, 3))), wd, st, 0, rd, er, w);
            if (wr && !exp_err) model_write(idx, wd, st);
            checks += 4;
            if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d]: idx=%0d got %h want %h", i, idx, rd, exp_rd); end
            if (er !== (SLVERR_EN & exp_err)) begin failures++; $display("FAIL rnd_err[%0d]: idx=%0d got %b want %b", i, idx, er, SLVERR_EN & exp_err); end
            if (start !== exp_start) begin failures++; $display("FAIL rnd_start[%0d]: got %b want %b", i, start, exp_start); end
            if (w !== WS) begin failures++; $display("FAIL rnd_waits[%0d]: got %0d want %0d", i, w, WS); end
        end
        busy = 0;
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (regs[r*BW +: BW] !== model_read(r, 1'b0)) begin
                failures++;
                $display("FAIL rnd_regs_o[%0d]: got %h want %h", r, regs[r*BW +: BW], model_read(r, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_strobes();
        test_ctrl_start();
        test_out_of_range();
        test_done();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/matmul_apb_slave.md
MATMUL_APB_SLAVE -- requirements
Module: matmul_apb_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, APB data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, APB byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, element width; STRB_WIDTH = BUS_WIDTH/DATA_WIDTH (BUS_WIDTH divisible by DATA_WIDTH).
REQ-004 SHALL have parameter NUM_REGS, default 8, register count (minimum 3).
REQ-005 SHALL have parameter WAIT_STATES, default 0, range 0..7, pready_o low cycles per access.
REQ-006 SHALL have one clock and asynchronous active-low reset; ports: clk_i  input  1  clock; rst_ni  input  1  async active-low reset.
REQ-007 SHALL have ports: psel_i  input  1  select; penable_i  input  1  access phase; pwrite_i  input  1  1=write.
REQ-008 SHALL have ports: pstrb_i  input  STRB_WIDTH  element-lane write strobes; pwdata_i  input  BUS_WIDTH  write data; paddr_i  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have ports: pready_o  output  1  transfer complete; pslverr_o  output  1  error; prdata_o  output  BUS_WIDTH  read data.
REQ-010 SHALL have ports: busy_i  input  1  engine busy; done_i  input  1  engine done pulse; busy_o  output  1  equals busy_i; start_o  output  1  start pulse; regs_o  output  NUM_REGS*BUS_WIDTH  flattened register contents, reg k at bits [k*BUS_WIDTH +: BUS_WIDTH].

Function
REQ-011 SHALL decode register index = paddr_i >> log2(BUS_WIDTH/8); low byte-offset bits ignored; index >= NUM_REGS is out of range.
REQ-012 SHALL map reg 0 = CTRL (bit0 START self-clearing, reads 0; bits[3:1] MODE r/w), reg 1 = STATUS (bit0 BUSY read-only = busy_i, bit1 DONE sticky), regs 2..NUM_REGS-1 = DATA r/w.
REQ-013 SHALL implement FSM IDLE/ACCESS: IDLE->ACCESS on psel_i=1 and penable_i=0, latching address, direction, data, strobes and loading wait counter with WAIT_STATES.
REQ-014 SHALL in ACCESS drive pready_o=1 exactly when counter=0, decrementing counter each cycle while nonzero.
REQ-015 SHALL complete the transfer on the edge where psel_i, penable_i, pready_o are all 1, then return to IDLE; back-to-back transfers start from IDLE.
REQ-016 SHALL return to IDLE without side effects if psel_i drops while in ACCESS.
REQ-017 SHALL write element lane k of a DATA/CTRL register only if pstrb_i[k]=1; reads ignore pstrb_i.
REQ-018 SHALL drive prdata_o with the addressed register whenever pready_o=1 on a read, else 0; out-of-range reads return 0.
REQ-019 SHALL pulse start_o high for exactly one cycle after a completed CTRL write with START=1 and lane 0 strobed while busy_i=0.
REQ-020 SHALL set DONE on done_i=1; a write of 1 to STATUS bit1 clears DONE; simultaneous done_i and clear leaves DONE=1.
REQ-021 SHALL block writes to DATA and CTRL while busy_i=1 (no register change, no start_o).
REQ-022 SHALL drive pslverr_o only while pready_o=1; flagged errors: out-of-range, write to STATUS with bit1=0 payload only, write while busy_i=1.

Reset
REQ-023 SHALL on rst_ni=0 immediately force FSM=IDLE, counter=0, all registers=0, DONE=0, pready_o=0, pslverr_o=0, prdata_o=0, start_o=0.
REQ-024 SHALL abort any in-flight transfer on reset without committing its write.

Configuration
REQ-025 SHALL, with macro MATMUL_APB_SLVERR_EN defined, report errors on pslverr_o per REQ-022.
REQ-026 SHALL, without MATMUL_APB_SLVERR_EN, tie pslverr_o to 0; illegal accesses still have no side effects and reads return 0.

Verification
REQ-027 SHALL cover: WAIT_STATES=2, write 0xA5A5A5A5 to addr 0x08 (reg 2), pstrb=4'b1111 -> pready_o low 2 cycles, then high 1 cycle; readback 0xA5A5A5A5, pslverr_o=0.
REQ-028 SHALL cover: reg 3 = 0, write 0x11223344 with pstrb=4'b0101 -> reg 3 reads 0x00220044.
REQ-029 SHALL cover: write CTRL=0x1 with busy_i=0 -> start_o one-cycle pulse, CTRL reads 0x0; repeat with busy_i=1 -> no pulse, pslverr_o=1 (macro defined).
REQ-030 SHALL cover: read addr 0x40 with NUM_REGS=8 -> prdata_o=0, pslverr_o=1 with macro, 0 without.
REQ-031 SHALL cover: done_i pulse -> STATUS reads 0x2; done_i coincident with write-1 clear -> STATUS still 0x2; clear alone -> 0x0.
REQ-032 SHALL cover: rst_ni low in ACCESS of write to reg 2 -> reg 2 remains 0, all outputs 0 during reset, next transfer completes normally.
